// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer_if
//  Purpose  : Request/result bundle between the controller and shift_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if #(
    parameter int WORD = 16
);
    localparam int CW = $clog2(WORD);

    logic            start;
    logic [1:0]      operation;
    logic [CW-1:0]   count;
    logic [WORD-1:0] in;
    logic [3:0]      status_in;
    logic            busy;
    logic            done;
    logic [WORD-1:0] out;
    logic [3:0]      status_out;

    modport master (
        output start, operation, count, in, status_in,
        input  busy, done, out, status_out
    );

    modport slave (
        input  start, operation, count, in, status_in,
        output busy, done, out, status_out
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Purpose  : Breaks an SRA/RRC-by-N request into N one-bit steps, one per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WORD = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    shift_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WORD);

    localparam logic [1:0]    OP_RRC  = 2'd1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam int C_BIT = 0;
    localparam int Z_BIT = 1;
    localparam int N_BIT = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WORD-1:0] out_q,   out_d;
    logic [3:0]      stat_q,  stat_d;
    logic [1:0]      op_q,    op_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            stat_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            stat_q  <= stat_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        stat_d  = stat_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    out_d  = bus.in;
                    stat_d = bus.status_in;
                    op_d   = bus.operation;
                    cnt_d  = bus.count;
                    if (bus.count == CNT_ZERO || bus.operation[1]) begin
                        state_d       = S_DONE;
                        stat_d[Z_BIT] = ~|bus.in;
                        stat_d[N_BIT] = bus.in[WORD-1];
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // RRC feeds the carry into the MSB; SRA replicates the sign bit.
                out_d         = {(op_q == OP_RRC) ? stat_q[C_BIT] : out_q[WORD-1],
                                 out_q[WORD-1:1]};
                stat_d[C_BIT] = out_q[0];
                cnt_d         = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d       = S_DONE;
                    stat_d[Z_BIT] = ~|out_d;
                    stat_d[N_BIT] = out_d[WORD-1];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.out        = out_q;
    assign bus.status_out = stat_q;
endmodule
`default_nettype wire
